lif_sweep_scheduler: RTL and testbench
======================================

// Module: lif_sweep_scheduler
// PURPOSE
//  Time-multiplexes one leaky-integrate-and-fire update datapath across N virtual neurons.
//  Each tick launches a sweep: one neuron per clock, in index order 0..N-1.
//  Per-neuron membrane state lives here; per-neuron input current is fetched through an indexed read port.
//  Sits between the stimulus/current source and the spike consumer.
//  Provides a configurable threshold and a fire-and-reset policy.
// PARAMETERS
//  N_NEURONS   8   number of virtual neurons (>=2)
//  W           8   width of current, state and threshold
//  LEAK_SHIFT  1   leak = state >> LEAK_SHIFT per update
//  THRESH_RST  32  threshold value loaded on reset
//  IDXW        $clog2(N_NEURONS)  index width (derived, localparam)
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  tick         in   1     start-sweep request, sampled only in IDLE
//  cfg_we       in   1     threshold write strobe
//  cfg_thresh   in   W     threshold value written when cfg_we=1
//  cur_idx      out  IDXW  neuron index whose current is needed this cycle
//  cur_data     in   W     current for cur_idx, valid same cycle (combinational read)
//  busy         out  1     high while sweeping
//  done         out  1     one-cycle pulse: sweep complete, spike_vec valid
//  spike_vec    out  N     spike flags of last completed sweep, bit i = neuron i
//  spike_total  out  16    running count of spikes since reset, wraps at 2^16
//  dbg_idx      in   IDXW  state readout select
//  dbg_state    out  W     state[dbg_idx], combinational
// BEHAVIOUR
//  Reset (async assert, sync-free deassert):
//   - All state[i]=0, threshold=THRESH_RST, FSM=IDLE, idx=0.
//   - Outputs: busy=0, done=0, spike_vec=0, spike_total=0, cur_idx=0.
//  FSM: IDLE, SWEEP.
//   - IDLE, tick=1: go to SWEEP, idx<=0, work spike register cleared.
//   - IDLE, tick=0: stay.
//   - SWEEP: busy=1, cur_idx=idx.
//  Update, every SWEEP cycle, written at the clock edge:
//   - sum = cur_data + (state[idx] >> LEAK_SHIFT), computed W+1 bits wide.
//   - nxt = sum clamped to 2^W-1 (saturate, never wrap).
//   - fire = (nxt >= threshold), unsigned compare.
//   - state[idx] <= fire ? 0 : nxt.
//   - work[idx] <= fire.
//   - spike_total += fire.
//  Sweep completion:
//   - idx<N-1: idx++.
//   - idx==N-1: same edge writes spike_vec <= work (including the last bit), done<=1 for one cycle, FSM->IDLE, idx<=0.
//  Latency:
//   - tick accepted at edge e0; neuron k is updated at edge e(k+1).
//   - done is high and spike_vec valid in the cycle after edge eN.
//  Throughput:
//   - tick may be asserted during the done cycle and is accepted, so back-to-back sweeps run every N+1 cycles.
//  Boundary conditions:
//   - tick while busy is ignored: not queued, no effect.
//   - spike_vec holds its value until the next sweep completes.
//   - cfg_we is legal any time; threshold updates at the edge.
//   - A neuron updated on the same edge as a cfg_we write uses the old threshold.
//   - Later neurons in the sweep use the new threshold.
//   - threshold=0: every neuron fires on every update.
//   - spike_total wraps from 16'hFFFF to 0.
//   - rst mid-sweep: busy drops immediately, all state is cleared, the partial sweep is discarded, done is not pulsed.
//  cur_idx outside SWEEP is 0; cur_data is don't-care outside SWEEP.
// TESTING
//  1. Reset checks:
//     - Assert rst -> busy=0, done=0, spike_vec=0, spike_total=0, dbg_state=0 for all idx.
//     - Fire test with cur=32 fires; cur=31 does not, confirming threshold=32.
//  2. cur_data=20 for all neurons, 3 ticks:
//     - Sweep 1: state 20, spike_vec=0.
//     - Sweep 2: state 30, spike_vec=0.
//     - Sweep 3: 35 fires, spike_vec=8'hFF, states 0, spike_total=8.
//  3. Saturation: state[2]=200, cur_data=250 -> nxt clamps to 255; at threshold 255 it fires and state[2]=0.
//  4. Timing:
//     - tick at e0 -> done high exactly in the cycle after e8.
//     - Extra ticks during busy produce no second sweep.
//     - tick in the done cycle starts a new sweep.
//  5. Mid-sweep threshold change:
//     - cfg_we with thresh=10 on the edge updating neuron 3, cur_data=15, states 0.
//     - Result: neurons 4..7 fire, 0..3 do not; spike_vec=8'hF0.
//  6. Mid-sweep reset:
//     - rst at neuron 5 -> busy low asynchronously, no done pulse.
//     - Next sweep sees all states 0.

Source files
------------

// File: rtl/lif_sweep_scheduler_if.sv
// Bus bundle for the LIF sweep scheduler: sweep control, threshold config,
// current fetch port, spike results and the state debug readout.
interface lif_sweep_scheduler_if #(
  parameter int unsigned N_NEURONS = 8,
  parameter int unsigned W         = 8
);
  localparam int unsigned IDXW = $clog2(N_NEURONS);

  logic                 tick;
  logic                 cfg_we;
  logic [W-1:0]         cfg_thresh;
  logic [IDXW-1:0]      cur_idx;
  logic [W-1:0]         cur_data;
  logic                 busy;
  logic                 done;
  logic [N_NEURONS-1:0] spike_vec;
  logic [15:0]          spike_total;
  logic [IDXW-1:0]      dbg_idx;
  logic [W-1:0]         dbg_state;

  // Stimulus / current source and spike consumer side
  modport master (
    output tick, cfg_we, cfg_thresh, cur_data, dbg_idx,
    input  cur_idx, busy, done, spike_vec, spike_total, dbg_state
  );

  // Scheduler side
  modport slave (
    input  tick, cfg_we, cfg_thresh, cur_data, dbg_idx,
    output cur_idx, busy, done, spike_vec, spike_total, dbg_state
  );
endinterface

// File: rtl/lif_sweep_scheduler.sv
// Leaky-integrate-and-fire sweep scheduler: one shared update datapath visits
// each virtual neuron once per tick, in index order, one neuron per clock.
module lif_sweep_scheduler #(
  parameter int unsigned N_NEURONS  = 8,
  parameter int unsigned W          = 8,
  parameter int unsigned LEAK_SHIFT = 1,
  parameter int unsigned THRESH_RST = 32
) (
  input logic                  clk,
  input logic                  rst,
  lif_sweep_scheduler_if.slave bus
);
  localparam int unsigned     IDXW    = $clog2(N_NEURONS);
  localparam logic [IDXW-1:0] LastIdx = IDXW'(N_NEURONS - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [W-1:0]         mem_q [N_NEURONS];
  logic [W-1:0]         mem_d [N_NEURONS];
  logic [W-1:0]         thresh_q, thresh_d;
  logic [N_NEURONS-1:0] work_q, work_d;
  logic [N_NEURONS-1:0] spike_vec_q, spike_vec_d;
  logic [15:0]          total_q, total_d;
  logic                 done_q, done_d;

  logic [W-1:0]         leak;
  logic [W:0]           sum;
  logic [W-1:0]         nxt;
  logic                 fire;

  // Update datapath: leak, integrate with one guard bit, saturate, compare
  always_comb begin
    leak = mem_q[idx_q] >> LEAK_SHIFT;
    sum  = {1'b0, bus.cur_data} + {1'b0, leak};
    nxt  = sum[W] ? {W{1'b1}} : sum[W-1:0];
    fire = (nxt >= thresh_q);
  end

  // Next-state: FSM, per-neuron state write-back, spike bookkeeping, config
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mem_d       = mem_q;
    thresh_d    = thresh_q;
    work_d      = work_q;
    spike_vec_d = spike_vec_q;
    total_d     = total_q;
    done_d      = 1'b0;

    // The neuron updated on this edge still compares against thresh_q
    if (bus.cfg_we) thresh_d = bus.cfg_thresh;

    unique case (state_q)
      StIdle: begin
        if (bus.tick) begin
          state_d = StSweep;
          idx_d   = '0;
          work_d  = '0;
        end
      end
      StSweep: begin
        mem_d[idx_q]  = fire ? '0 : nxt;
        work_d[idx_q] = fire;
        total_d       = total_q + 16'(fire);
        if (idx_q == LastIdx) begin
          // work_d already carries the last neuron's bit
          spike_vec_d = work_d;
          done_d      = 1'b1;
          state_d     = StIdle;
          idx_d       = '0;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      mem_q       <= '{default: '0};
      thresh_q    <= W'(THRESH_RST);
      work_q      <= '0;
      spike_vec_q <= '0;
      total_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mem_q       <= mem_d;
      thresh_q    <= thresh_d;
      work_q      <= work_d;
      spike_vec_q <= spike_vec_d;
      total_q     <= total_d;
      done_q      <= done_d;
    end
  end

  // Outputs: busy follows the state register so reset drops it at once
  always_comb begin
    bus.busy        = (state_q == StSweep);
    bus.cur_idx     = (state_q == StSweep) ? idx_q : '0;
    bus.done        = done_q;
    bus.spike_vec   = spike_vec_q;
    bus.spike_total = total_q;
    bus.dbg_state   = mem_q[bus.dbg_idx];
  end
endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// Self-checking bench for lif_sweep_scheduler: a behavioural neuron model
// predicts each sweep's spikes; expectations queue up at launch and are
// compared when done pulses.
module tb_lif_sweep_scheduler;
  localparam int N = 8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cur_tab [N];

  lif_sweep_scheduler_if #(.N_NEURONS(N), .W(W)) bus ();

  assign bus.cur_data = cur_tab[bus.cur_idx];

  lif_sweep_scheduler #(
    .N_NEURONS (N),
    .W         (W),
    .LEAK_SHIFT(1),
    .THRESH_RST(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_state [N];
  logic [W-1:0] m_thresh;
  logic [15:0]  m_total;
  logic [N-1:0] q_vec[$];
  logic [15:0]  q_total[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_state[i] = '0;
    m_thresh = 8'd32;
    m_total  = '0;
    q_vec.delete();
    q_total.delete();
  endtask

  task automatic set_cur(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) cur_tab[i] = v;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.cfg_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_thresh(input logic [W-1:0] v);
    @(negedge clk);
    bus.cfg_we = 1'b1;
    bus.cfg_thresh = v;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    m_thresh = v;
  endtask

  // Called at a negedge; launches a sweep at the next posedge. cfg_at >= 0
  // writes cfg_val while neuron cfg_at is being updated. Returns in the done
  // cycle with tick = chain so a following call runs back-to-back.
  task automatic do_sweep(input int cfg_at, input logic [W-1:0] cfg_val,
                          input bit extra_tick, input bit chain);
    logic [N-1:0] exp_vec;
    logic [N-1:0] ev;
    logic [15:0]  et;
    logic [W-1:0] nxt;
    logic [W-1:0] thr;
    int           sum;
    for (int k = 0; k < N; k++) begin
      sum = int'(cur_tab[k]) + int'(m_state[k] >> 1);
      nxt = (sum > 255) ? 8'd255 : sum[7:0];
      thr = (cfg_at >= 0 && k > cfg_at) ? cfg_val : m_thresh;
      exp_vec[k] = (nxt >= thr);
      m_state[k] = exp_vec[k] ? 8'd0 : nxt;
      if (exp_vec[k]) m_total = m_total + 16'd1;
    end
    if (cfg_at >= 0) m_thresh = cfg_val;
    q_vec.push_back(exp_vec);
    q_total.push_back(m_total);

    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = extra_tick;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.cur_idx !== 3'(k)) begin
        errors++;
        $display("FAIL sweep_idx k=%0d: got busy=%b cur_idx=%0d, expected busy=1 cur_idx=%0d",
                 k, bus.busy, bus.cur_idx, k);
      end
      bus.cfg_we = (k == cfg_at);
      bus.cfg_thresh = cfg_val;
      @(negedge clk);
    end
    bus.cfg_we = 1'b0;
    bus.tick = chain;

    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b, expected done=1 busy=0",
               bus.done, bus.busy);
    end
    ev = q_vec.pop_front();
    et = q_total.pop_front();
    checks++;
    if (bus.spike_vec !== ev) begin
      errors++;
      $display("FAIL spike_vec: got %h expected %h", bus.spike_vec, ev);
    end
    checks++;
    if (bus.spike_total !== et) begin
      errors++;
      $display("FAIL spike_total: got %0d expected %0d", bus.spike_total, et);
    end
    for (int k = 0; k < N; k++) begin
      bus.dbg_idx = 3'(k);
      #1;
      checks++;
      if (bus.dbg_state !== m_state[k]) begin
        errors++;
        $display("FAIL state[%0d]: got %0d expected %0d", k, bus.dbg_state, m_state[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_thresh = '0;
    bus.dbg_idx = '0;
    set_cur(8'd0);
    model_reset();
    #3;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cur_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b done=%b cur_idx=%0d, expected 0 0 0",
               bus.busy, bus.done, bus.cur_idx);
    end
    checks++;
    if (bus.spike_vec !== 8'h00 || bus.spike_total !== 16'd0) begin
      errors++;
      $display("FAIL reset_out: got spike_vec=%h spike_total=%0d, expected 00 0",
               bus.spike_vec, bus.spike_total);
    end
    for (int k = 0; k < N; k++) begin
      bus.dbg_idx = 3'(k);
      #1;
      checks++;
      if (bus.dbg_state !== 8'd0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %0d expected 0", k, bus.dbg_state);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fire_threshold();
    set_cur(8'd0);
    cur_tab[0] = 8'd32;
    cur_tab[1] = 8'd31;
    @(negedge clk);
    do_sweep(-1, 8'd0, 1'b0, 1'b0);
    checks++;
    if (bus.spike_vec !== 8'h01) begin
      errors++;
      $display("FAIL reset_thresh: got spike_vec=%h expected 01", bus.spike_vec);
    end
  endtask

  task automatic test_accumulate();
    logic [N-1:0] want_vec [3];
    logic [W-1:0] want_st  [3];
    want_vec[0] = 8'h00; want_vec[1] = 8'h00; want_vec[2] = 8'hFF;
    want_st[0]  = 8'd20; want_st[1]  = 8'd30; want_st[2]  = 8'd0;
    apply_reset();
    set_cur(8'd20);
    for (int s = 0; s < 3; s++) begin
      do_sweep(-1, 8'd0, 1'b0, 1'b0);
      bus.dbg_idx = 3'd6;
      #1;
      checks++;
      if (bus.spike_vec !== want_vec[s] || bus.dbg_state !== want_st[s]) begin
        errors++;
        $display("FAIL accum sweep %0d: got vec=%h state6=%0d expected vec=%h state6=%0d",
                 s + 1, bus.spike_vec, bus.dbg_state, want_vec[s], want_st[s]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.spike_total !== 16'd8) begin
      errors++;
      $display("FAIL accum_total: got %0d expected 8", bus.spike_total);
    end
  endtask

  task automatic test_saturation();
    set_thresh(8'd255);
    set_cur(8'd0);
    cur_tab[2] = 8'd200;
    @(negedge clk);
    do_sweep(-1, 8'd0, 1'b0, 1'b0);
    cur_tab[2] = 8'd250;
    @(negedge clk);
    do_sweep(-1, 8'd0, 1'b0, 1'b0);
    bus.dbg_idx = 3'd2;
    #1;
    checks++;
    if (bus.spike_vec !== 8'h04 || bus.dbg_state !== 8'd0) begin
      errors++;
      $display("FAIL saturate: got vec=%h state2=%0d expected vec=04 state2=0",
               bus.spike_vec, bus.dbg_state);
    end
    set_thresh(8'd0);
    set_cur(8'd0);
    @(negedge clk);
    do_sweep(-1, 8'd0, 1'b0, 1'b0);
    checks++;
    if (bus.spike_vec !== 8'hFF) begin
      errors++;
      $display("FAIL thresh_zero: got vec=%h expected FF", bus.spike_vec);
    end
  endtask

  task automatic test_back_to_back();
    set_thresh(8'd32);
    set_cur(8'd20);
    @(negedge clk);
    // tick held through the whole sweep must not queue a second one
    do_sweep(-1, 8'd0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL busy_tick_ignored: got busy=%b done=%b expected 0 0",
               bus.busy, bus.done);
    end
    do_sweep(-1, 8'd0, 1'b0, 1'b1);
    do_sweep(-1, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_mid_thresh();
    apply_reset();
    set_cur(8'd15);
    @(negedge clk);
    do_sweep(3, 8'd10, 1'b0, 1'b0);
    checks++;
    if (bus.spike_vec !== 8'hF0) begin
      errors++;
      $display("FAIL mid_thresh: got vec=%h expected F0", bus.spike_vec);
    end
  endtask

  task automatic test_mid_reset();
    int done_seen;
    set_cur(8'd20);
    @(negedge clk);
    do_sweep(-1, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.cur_idx !== 3'd5 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_idx: got cur_idx=%0d busy=%b expected 5 1",
               bus.cur_idx, bus.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL no_done_after_reset: got %0d done cycles expected 0", done_seen);
    end
    set_cur(8'd15);
    do_sweep(-1, 8'd0, 1'b0, 1'b0);
    bus.dbg_idx = 3'd7;
    #1;
    checks++;
    if (bus.spike_vec !== 8'h00 || bus.dbg_state !== 8'd15) begin
      errors++;
      $display("FAIL post_reset_sweep: got vec=%h state7=%0d expected 00 15",
               bus.spike_vec, bus.dbg_state);
    end
  endtask

  initial begin
    test_reset();
    test_fire_threshold();
    test_accumulate();
    test_saturation();
    test_back_to_back();
    test_mid_thresh();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
